// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: RAW-hazard scoreboard, stall/bubble/issue and halt-drain FSM; define PIPE_FWD_EN for EX_WB forwarding
module pipe_issue_ctrl #(
  parameter int NREGS  = 4,
  parameter int WB_LAT = 2,
  parameter int STAT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [1:0]                 id_opcode,
  input  logic [$clog2(NREGS)-1:0]   id_rd,
  input  logic [$clog2(NREGS)-1:0]   id_rs,
  input  logic                       halt_req,
  input  logic                       resume,
  output logic                       stall,
  output logic                       bubble,
  output logic                       issue,
  output logic                       fwd_op1,
  output logic                       fwd_op2,
  output logic                       halted,
  output logic [STAT_W-1:0]          stall_cycles
);
  localparam int IW = $clog2(NREGS);
  localparam logic [1:0] LAT = 2'(WB_LAT);
`ifdef PIPE_FWD_EN
  localparam logic [1:0] THR = 2'd1;
`else
  localparam logic [1:0] THR = 2'd0;
`endif
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, nxt;
  logic [1:0] cnt [NREGS];
  logic reads, writes, hazard, clean;
  logic [1:0] c1, c2;
  always_comb begin
    reads  = ~id_opcode[1];
    writes = id_opcode != 2'b11;
    c1     = cnt[id_rd];
    c2     = cnt[id_rs];
    hazard = reads & ((c1 > THR) | (c2 > THR));
    clean  = 1'b1;
    for (int i = 0; i < NREGS; i++) clean = clean & (cnt[i] == 2'd0);
    halted = state == HALTED;
    issue  = state == RUN ? id_valid & ~hazard & ~halt_req : 1'b0;
    stall  = state == RUN ? id_valid & (hazard | halt_req) : 1'b1;
    bubble = stall;
    nxt    = state == RUN   ? (halt_req ? DRAIN : RUN) :
             state == DRAIN ? (clean ? HALTED : DRAIN) :
                              (resume & ~halt_req ? RUN : HALTED);
  end
`ifdef PIPE_FWD_EN
  assign fwd_op1 = issue & reads & (c1 == 2'd1);
  assign fwd_op2 = issue & reads & (c2 == 2'd1);
`else
  assign fwd_op1 = 1'b0;
  assign fwd_op2 = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      stall_cycles <= '0;
      for (int i = 0; i < NREGS; i++) cnt[i] <= 2'd0;
    end else begin
      state <= nxt;
      if (state == RUN && stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      // a reload of the issuing destination takes priority over its countdown
      for (int i = 0; i < NREGS; i++)
        cnt[i] <= (issue && writes && id_rd == IW'(i)) ? LAT :
                  (cnt[i] != 2'd0) ? cnt[i] - 2'd1 : 2'd0;
    end
  end
endmodule
